// File: rtl/fifo_wr_arb.sv
// Round-robin write arbiter: NREQ valid/ready requesters share one synchronous FIFO write port.
// A winner owns the port until end-of-packet or BURST_MAX beats, then the search restarts after it.

module fifo_wr_arb_lane #(
    parameter int WIDTH = 8
) (
    input  logic             sel,
    input  logic             valid,
    input  logic             last,
    input  logic [WIDTH-1:0] data,
    input  logic             fifo_full,
    output logic             ready,
    output logic             wen,
    output logic             last_hit,
    output logic [WIDTH-1:0] data_out
);
    // sel is only ever set while the arbiter is in OWN, so it gates everything.
    assign ready    = sel & ~fifo_full;
    assign wen      = ready & valid;
    assign last_hit = wen & last;
    assign data_out = sel ? data : '0;
endmodule

module fifo_wr_arb #(
    parameter int WIDTH     = 8,
    parameter int NREQ      = 4,
    parameter int BURST_MAX = 16,
    parameter int ID_WIDTH  = $clog2(NREQ)
) (
    input  logic                    clk,
    input  logic                    arst_n,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ*WIDTH-1:0]   req_data,
    input  logic [NREQ-1:0]         req_last,
    output logic [NREQ-1:0]         req_ready,
    input  logic                    fifo_full,
    output logic                    fifo_wen,
    output logic [WIDTH-1:0]        fifo_data,
    output logic [NREQ-1:0]         grant,
    output logic [ID_WIDTH-1:0]     grant_id,
    output logic                    busy
);
    localparam int CNT_W = $clog2(BURST_MAX + 1);

    typedef enum logic {IDLE = 1'b0, OWN = 1'b1} state_t;

    state_t                          state, state_nxt;
    logic [ID_WIDTH-1:0]             last_owner;
    logic [CNT_W-1:0]                beat_cnt;
    logic [NREQ-1:0]                 lane_wen, lane_last;
    logic [NREQ-1:0][WIDTH-1:0]      lane_data;
    logic                            xfer, xfer_last, burst_end, release_own;
    logic                            pick_found;
    logic [ID_WIDTH-1:0]             pick_id;

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_lane
            fifo_wr_arb_lane #(.WIDTH(WIDTH)) u_lane (
                .sel       (grant[gi]),
                .valid     (req_valid[gi]),
                .last      (req_last[gi]),
                .data      (req_data[gi*WIDTH +: WIDTH]),
                .fifo_full (fifo_full),
                .ready     (req_ready[gi]),
                .wen       (lane_wen[gi]),
                .last_hit  (lane_last[gi]),
                .data_out  (lane_data[gi])
            );
        end
    endgenerate

    assign fifo_wen    = |lane_wen;
    assign xfer        = fifo_wen;
    assign xfer_last   = |lane_last;
    assign burst_end   = (beat_cnt == CNT_W'(BURST_MAX - 1));
    assign release_own = xfer & (xfer_last | burst_end);

    // grant is one-hot or zero, so an AND-OR mux is enough.
    always_comb begin
        fifo_data = '0;
        for (int i = 0; i < NREQ; i++)
            fifo_data = fifo_data | lane_data[i];
    end

    // Round-robin search starting just after the previous owner.
    always_comb begin
        int idx;
        idx        = 0;
        pick_found = 1'b0;
        pick_id    = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(last_owner) + k) % NREQ;
            if (!pick_found && req_valid[idx]) begin
                pick_found = 1'b1;
                pick_id    = ID_WIDTH'(idx);
            end
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (pick_found)  state_nxt = OWN;
            OWN:     if (release_own) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == OWN);
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            grant      <= '0;
            grant_id   <= '0;
            last_owner <= ID_WIDTH'(NREQ - 1);
            beat_cnt   <= '0;
        end else if (state == IDLE) begin
            if (pick_found) begin
                grant    <= NREQ'(1) << pick_id;
                grant_id <= pick_id;
                beat_cnt <= '0;
            end
        end else if (release_own) begin
            // A BURST_MAX cut releases exactly like end-of-packet; no lock is kept.
            grant      <= '0;
            last_owner <= grant_id;
            beat_cnt   <= '0;
        end else if (xfer) begin
            beat_cnt <= beat_cnt + CNT_W'(1);
        end
    end
endmodule

// File: doc/fifo_wr_arb.md
FIFO_WR_ARB -- requirements
Module: fifo_wr_arb

Interface
REQ-001 Parameter WIDTH, default 8: data width per requester, equal to the downstream FIFO WIDTH.
REQ-002 Parameter NREQ, default 4: number of write requesters, range 2..16.
REQ-003 Parameter BURST_MAX, default 16: maximum beats per grant, range 1..255.
REQ-004 Parameter ID_WIDTH, default $clog2(NREQ): width of grant_id.
REQ-005 clk  input  1  single clock; all state updates on the rising edge.
REQ-006 arst_n  input  1  asynchronous reset, active-low.
REQ-007 req_valid  input  NREQ  per-requester beat valid.
REQ-008 req_data  input  NREQ*WIDTH  per-requester beat; requester i occupies bits [i*WIDTH +: WIDTH].
REQ-009 req_last  input  NREQ  per-requester end-of-packet marker, qualified by req_valid.
REQ-010 req_ready  output  NREQ  per-requester beat accept.
REQ-011 fifo_full  input  1  full flag from the downstream synchronous FIFO.
REQ-012 fifo_wen  output  1  write enable to the FIFO.
REQ-013 fifo_data  output  WIDTH  write data to the FIFO.
REQ-014 grant  output  NREQ  one-hot current owner; all zeros when no owner.
REQ-015 grant_id  output  ID_WIDTH  binary index of the owner; holds the last owner when idle.
REQ-016 busy  output  1  high while any requester owns the FIFO write port.

Function
REQ-017 Two-state FSM: IDLE (no owner) and OWN (grant held by one requester).
REQ-018 IDLE with any req_valid high: pick a requester round-robin, searching from last_owner+1 upward with wrap. Register the winner into grant/grant_id and go to OWN on that edge. Arbitration costs exactly one cycle; no beat transfers in IDLE.
REQ-019 IDLE with no req_valid: stay in IDLE with grant = 0.
REQ-020 OWN, owner g: req_ready[g] = ~fifo_full (combinational); every other req_ready bit = 0.
REQ-021 OWN: fifo_wen = req_valid[g] & ~fifo_full and fifo_data = req_data[g], both combinational. Zero added latency from requester to FIFO.
REQ-022 fifo_wen is never high while fifo_full is high, including the cycle in which full asserts, because the FIFO RAM writes on wen regardless of full.
REQ-023 fifo_wen = 0 and fifo_data = 0 in IDLE and during reset.
REQ-024 A transfer is a cycle with fifo_wen = 1. Each transfer increments beat_cnt, width $clog2(BURST_MAX+1). beat_cnt clears on entry to OWN.
REQ-025 OWN -> IDLE on a transfer with req_last[g] = 1, or on the transfer that brings beat_cnt to BURST_MAX, whichever comes first. On that edge last_owner <= g and grant clears.
REQ-026 A burst cut by BURST_MAX does not carry a packet lock. The remainder of the packet re-arbitrates like a new request.
REQ-027 In OWN with req_valid[g] low, hold the grant indefinitely; there is no timeout and no preemption.
REQ-028 In OWN, valid from other requesters is ignored. Those requesters see req_ready = 0 and hold their data (standard valid/ready; a beat is consumed only when valid & ready).
REQ-029 Requests arriving in the release cycle are considered only in the following IDLE cycle, which gives a minimum one-cycle gap between owners.
REQ-030 Fairness: with all NREQ requesters continuously valid, grants rotate 0,1,...,NREQ-1,0,... with no requester skipped.
REQ-031 busy = (state == OWN).

Reset
REQ-032 arst_n low: asynchronously force state = IDLE, grant = 0, grant_id = 0, last_owner = NREQ-1 (requester 0 wins first), beat_cnt = 0, busy = 0, req_ready = 0, fifo_wen = 0.
REQ-033 Reset asserted mid-burst: drop the grant immediately with no further fifo_wen. Any partial packet already written stays in the FIFO; FIFO reset is the integrator's responsibility.
REQ-034 Deassertion of arst_n is synchronised externally; the first arbitration may occur on the first rising edge after release.

Verification
REQ-035 After reset, req_valid = 4'b1111 with req_last high on every beat -> grant sequence 0,1,2,3,0; one beat per grant; fifo_wen pattern 0,1,0,1,...
REQ-036 Requester 2 sends a 5-beat packet (req_last on beat 5), FIFO never full -> grant_id = 2 for 5 consecutive fifo_wen cycles, then busy drops.
REQ-037 BURST_MAX = 16, requester 1 sends 20 beats with no req_last, requester 3 also valid -> 16 beats from 1, release, grant to 3, then 1 regains the grant for the remaining 4 beats.
REQ-038 fifo_full rises mid-burst for 3 cycles -> fifo_wen and req_ready[g] are 0 for exactly those 3 cycles, the grant is held, and no beat is lost or duplicated (scoreboard checks FIFO contents).
REQ-039 arst_n pulsed low mid-burst -> grant, busy and fifo_wen are 0 in the same cycle without waiting for a clock edge; after release, requester 0 has first priority.
REQ-040 Random valid/last/full traffic for 100k cycles -> assertions: grant is one-hot or zero; fifo_wen is never high with fifo_full; per-requester packet order is preserved in the FIFO; no starvation beyond NREQ*BURST_MAX+2*NREQ cycles.
